// File: rtl/netclk_gen_pkg.sv
// Shared definitions for the netlist clock generator: state encodings and default widths.
package netclk_gen_pkg;

  localparam logic [1:0] NETCLK_IDLE = 2'd0;
  localparam logic [1:0] NETCLK_RUN  = 2'd1;
  localparam logic [1:0] NETCLK_STOP = 2'd2;

  localparam int unsigned NETCLK_DIV_W = 8;
  localparam int unsigned NETCLK_CNT_W = 16;

endpackage

// File: rtl/netclk_gen_divcnt.sv
// Loadable down-counter with zero flag; times the half-periods of the generated clock.
module netclk_divcnt
  import netclk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = NETCLK_DIV_W
) (
  input  logic             sys_clk,
  input  logic             cd,
  input  logic             load,
  input  logic             dec,
  input  logic [DIV_W-1:0] load_val,
  output logic [DIV_W-1:0] cnt,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q;

  // Load has priority over decrement; the counter holds when neither is requested.
  always_ff @(posedge sys_clk or negedge cd) begin
    if (!cd) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/netclk_gen.sv
// Netlist clock generator: drives cp with programmable half-period (div+1 cycles), parks it low
// on request without truncating a high phase, and provides edge strobes and a rising-edge count.
// Define NETCLK_PHASE2_EN to generate the non-overlapping second phase cp2; otherwise cp2 is 0.
module netclk_gen
  import netclk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = NETCLK_DIV_W,
  parameter int unsigned CNT_W = NETCLK_CNT_W
) (
  input  logic             sys_clk,
  input  logic             cd,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             cp,
  output logic             cp2,
  output logic             rise,
  output logic             fall,
  output logic             running,
  output logic [CNT_W-1:0] edges
);

  logic [1:0]       state_q, state_d;
  logic             cp_q, cp_d;
  logic             cp2_q, cp2_d;
  logic             rise_q, fall_q, running_q;
  logic [CNT_W-1:0] edges_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [DIV_W-1:0] cnt;

  netclk_divcnt #(
    .DIV_W (DIV_W)
  ) u_divcnt (
    .sys_clk  (sys_clk),
    .cd       (cd),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (div),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Next state, next cp level and counter control; stop is judged on the post-toggle cp.
  always_comb begin
    state_d  = state_q;
    cp_d     = cp_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      NETCLK_IDLE: begin
        cp_d = 1'b0;
        if (run) begin
          cnt_load = 1'b1;
          state_d  = NETCLK_RUN;
        end
      end
      NETCLK_RUN: begin
        if (cnt_zero) begin
          cp_d     = ~cp_q;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
        if (!run) begin
          state_d = cp_d ? NETCLK_STOP : NETCLK_IDLE;
        end
      end
      NETCLK_STOP: begin
        // Finish the high phase as loaded at its rising toggle, then park low.
        if (cnt_zero) begin
          cp_d    = 1'b0;
          state_d = NETCLK_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        cp_d    = 1'b0;
        state_d = NETCLK_IDLE;
      end
    endcase
  end

`ifdef NETCLK_PHASE2_EN
  // Inside a low half: a decrement means not the first cycle, a nonzero result not the last.
  assign cp2_d = (state_d == NETCLK_RUN) && !cp_d && cnt_dec && (cnt != DIV_W'(1));
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
  assign cp2_d      = 1'b0;
`endif

  // All outputs are registered alongside cp so strobes line up with the first cycle of a level.
  always_ff @(posedge sys_clk or negedge cd) begin
    if (!cd) begin
      state_q   <= NETCLK_IDLE;
      cp_q      <= 1'b0;
      cp2_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      running_q <= 1'b0;
      edges_q   <= '0;
    end else begin
      state_q   <= state_d;
      cp_q      <= cp_d;
      cp2_q     <= cp2_d;
      rise_q    <= cp_d & ~cp_q;
      fall_q    <= ~cp_d & cp_q;
      running_q <= (state_d != NETCLK_IDLE);
      edges_q   <= edges_q + CNT_W'(cp_d & ~cp_q);
    end
  end

  assign cp      = cp_q;
  assign cp2     = cp2_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign running = running_q;
  assign edges   = edges_q;

endmodule

// File: tb/tb_netclk_gen.sv
// Randomised scoreboard bench for netclk_gen with a half-period-position reference model.
module tb_netclk_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 8;  // narrow counter so wrap-around is reachable quickly

  logic             sys_clk = 1'b0;
  logic             cd, run;
  logic [DIV_W-1:0] div;
  logic             cp, cp2, rise, fall, running;
  logic [CNT_W-1:0] edges;

  netclk_gen #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .sys_clk (sys_clk),
    .cd      (cd),
    .run     (run),
    .div     (div),
    .cp      (cp),
    .cp2     (cp2),
    .rise    (rise),
    .fall    (fall),
    .running (running),
    .edges   (edges)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic             cp;
    logic             cp2;
    logic             rise;
    logic             fall;
    logic             running;
    logic [CNT_W-1:0] edges;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 parked, 1 generating, 2 finishing a high phase.
  // m_len is the length of the current half, m_pos how many of its cycles have elapsed.
  int   m_mode, m_len, m_pos, m_edges;
  logic m_cp;
  out_t m_out;

  task automatic model_reset();
    m_mode  = 0;
    m_cp    = 1'b0;
    m_len   = 1;
    m_pos   = 0;
    m_edges = 0;
    m_out   = '0;
  endtask

  task automatic model_step(input logic r, input int d);
    logic prev;
    bit   flipped;
    prev      = m_cp;
    flipped   = 0;
    m_out.cp2 = 1'b0;
    if (m_mode == 0) begin
      if (r) begin
        m_mode = 1;
        m_len  = d + 1;
        m_pos  = 0;
      end
    end else begin
      if (m_pos == m_len - 1) begin
        m_cp    = !m_cp;
        m_len   = d + 1;
        m_pos   = 0;
        flipped = 1;
      end else begin
        m_pos++;
      end
      if (m_mode == 2) begin
        if (flipped) m_mode = 0;
      end else if (!r) begin
        m_mode = m_cp ? 2 : 0;
      end
`ifdef NETCLK_PHASE2_EN
      if (m_mode == 1 && !m_cp && m_pos >= 1 && m_pos <= m_len - 2) m_out.cp2 = 1'b1;
`endif
    end
    m_out.cp      = m_cp;
    m_out.rise    = m_cp && !prev;
    m_out.fall    = !m_cp && prev;
    m_out.running = (m_mode != 0);
    if (m_out.rise) m_edges = (m_edges + 1) % (1 << CNT_W);
    m_out.edges   = CNT_W'(m_edges);
  endtask

  function automatic out_t sample();
    out_t g;
    g = {cp, cp2, rise, fall, running, edges};
    return g;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("cp=%b cp2=%b rise=%b fall=%b running=%b edges=%0d",
                     o.cp, o.cp2, o.rise, o.fall, o.running, o.edges);
  endfunction

  // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
  initial begin
    out_t e, g;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got {%s} expected {%s}", $time, fmt(g), fmt(e));
        end
      end
    end
  end

  task automatic check_zero(input string name);
    out_t g;
    g = sample();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL %s t=%0t got {%s} expected all zero", name, $time, fmt(g));
    end
  endtask

  task automatic cycle(input logic r, input int d);
    @(negedge sys_clk);
    run = r;
    div = DIV_W'(d);
    model_step(r, d);
    exp_q.push_back(m_out);
  endtask

  task automatic release_cycle(input logic r, input int d);
    @(negedge sys_clk);
    cd  = 1'b1;
    run = r;
    div = DIV_W'(d);
    model_step(r, d);
    exp_q.push_back(m_out);
  endtask

  // Asynchronous reset between clock edges, held across edges with run requested.
  task automatic do_reset();
    @(negedge sys_clk);
    #2;
    cd  = 1'b0;
    run = 1'b1;
    div = '0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge sys_clk);
    #1;
    check_zero("reset_hold");
    model_reset();
  endtask

  initial begin
    int d, guard;
    logic r;
    cd  = 1'b0;
    run = 1'b0;
    div = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_zero("reset_values");

    // div=3: first rise after 4 cycles, period 8
    release_cycle(1'b1, 3);
    repeat (40) cycle(1'b1, 3);
    repeat (6) cycle(1'b0, 3);

    // div=0 for 10 cycles
    repeat (10) cycle(1'b1, 0);
    repeat (4) cycle(1'b0, 0);

    // div=5, drop run shortly after a rise
    guard = 0;
    do begin
      cycle(1'b1, 5);
      guard++;
    end while (!m_out.rise && guard < 50);
    cycle(1'b1, 5);
    repeat (16) cycle(1'b0, 5);

    // div 2 -> 7 during a high phase
    guard = 0;
    do begin
      cycle(1'b1, 2);
      guard++;
    end while (!m_out.rise && guard < 50);
    repeat (40) cycle(1'b1, 7);
    repeat (10) cycle(1'b0, 7);

    // second-phase windows: div=3 then div=1, then div=2 edge case
    repeat (24) cycle(1'b1, 3);
    repeat (12) cycle(1'b1, 1);
    repeat (12) cycle(1'b1, 2);

    // random traffic
    d = 3;
    r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 6);
      if ($urandom_range(0, 23) == 0) r = !r;
      cycle(r, d);
    end

    // reach edges at all-ones with cp high, then reset asynchronously
    guard = 0;
    do begin
      cycle(1'b1, 0);
      guard++;
    end while (!(m_edges == (1 << CNT_W) - 1 && m_cp) && guard < 1200);
    if (guard >= 1200) begin
      errors++;
      $display("FAIL wrap_setup_timeout model never reached edges=all-ones with cp=1");
    end
    do_reset();
    release_cycle(1'b1, 0);
    repeat (8) cycle(1'b1, 0);

    // wrap-around of the edge counter
    guard = 0;
    do begin
      cycle(1'b1, 0);
      guard++;
    end while (m_edges != (1 << CNT_W) - 1 && guard < 1200);
    repeat (6) cycle(1'b1, 0);
    repeat (4) cycle(1'b0, 0);

    @(posedge sys_clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
